// File: rtl/onehot_stream_decoder.sv
// rtl/onehot_stream_decoder.sv - streaming binary-to-one-hot decoder with 2-entry skid buffer and saturating word counter
// Optional feature macro: DEC_PARITY_EN (adds in_par/par_err, drops words with bad even parity)
module onehot_stream_decoder #(
  parameter int CODE_W = 2,
  parameter int CNT_W  = 8,
  localparam int N_OUT = 2 ** CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
`ifdef DEC_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_onehot,
  output logic [CODE_W-1:0] out_code,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  word_cnt
);

  // Stage occupancy: output register only, or output register plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  out_code_q, out_code_d;
  logic [CODE_W-1:0]  skid_code_q, skid_code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic accept;
  logic consume;
  logic code_ok;
  logic fwd;

  // Ready depends only on registered occupancy, so no path from out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign fwd       = accept & code_ok;

  assign out_code   = out_code_q;
  assign out_onehot = out_valid ? ({{(N_OUT-1){1'b0}}, 1'b1} << out_code_q) : '0;
  assign word_cnt   = cnt_q;

`ifdef DEC_PARITY_EN
  logic par_err_q, par_err_d;

  assign code_ok = ~(^{in_code, in_par});
  assign par_err = par_err_q;

  // Sticky flag: any accepted word with odd overall parity sets it until reset.
  always_comb begin
    par_err_d = par_err_q | (accept & ~code_ok);
  end

  // Parity error flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
`else
  assign code_ok = 1'b1;
`endif

  // Occupancy next-state and data steering; skid always drains before new input.
  always_comb begin
    state_d     = state_q;
    out_code_d  = out_code_q;
    skid_code_d = skid_code_q;
    case (state_q)
      ST_EMPTY: begin
        if (fwd) begin
          out_code_d = in_code;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (consume) begin
          if (fwd) out_code_d = in_code;
          else     state_d    = ST_EMPTY;
        end else if (fwd) begin
          skid_code_d = in_code;
          state_d     = ST_TWO;
        end
      end
      ST_TWO: begin
        if (consume) begin
          out_code_d = skid_code_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Delivered-word counter: clear wins over increment, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                            cnt_d = '0;
    else if (consume && (cnt_q != '1))      cnt_d = cnt_q + CNT_W'(1);
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_code_q  <= '0;
      skid_code_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_code_q  <= out_code_d;
      skid_code_q <= skid_code_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_onehot_stream_decoder.sv
// tb/tb_onehot_stream_decoder.sv - scoreboard bench for onehot_stream_decoder
module tb_onehot_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'd0;
  logic       in_par = 1'b0;
  logic       out_ready = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       in_ready, out_valid;
  logic [3:0] out_onehot;
  logic [1:0] out_code;
  logic [7:0] word_cnt;

  logic       in_ready_c, out_valid_c;
  logic [3:0] out_onehot_c;
  logic [1:0] out_code_c;
  logic [1:0] word_cnt_c;

`ifdef DEC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  logic par_err, par_err_c;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  onehot_stream_decoder #(.CODE_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par), .par_err(par_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot), .out_code(out_code),
    .cnt_clr(cnt_clr), .word_cnt(word_cnt)
  );

  onehot_stream_decoder #(.CODE_W(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par), .par_err(par_err_c),
`endif
    .out_valid(out_valid_c), .out_ready(out_ready), .out_onehot(out_onehot_c), .out_code(out_code_c),
    .cnt_clr(cnt_clr), .word_cnt(word_cnt_c)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] sb_q[$];
  int         mcnt = 0;
  int         mcnt_c = 0;
  logic       mpar = 1'b0;

  int         sz;
  logic [1:0] front;
  logic       hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare visible DUT state with the model, then predict the coming edge.
  always @(negedge clk) begin
    sz = sb_q.size();
    chk("out_valid", out_valid, sz > 0);
    chk("in_ready", in_ready, sz < 2);
    chk("out_valid_c", out_valid_c, sz > 0);
    chk("in_ready_c", in_ready_c, sz < 2);
    if (sz > 0) begin
      front = sb_q[0];
      chk("out_code", out_code, front);
      chk("out_onehot", out_onehot, 4'b0001 << front);
      chk("out_code_c", out_code_c, front);
      chk("out_onehot_c", out_onehot_c, 4'b0001 << front);
    end else begin
      chk("out_onehot_idle", out_onehot, 0);
      chk("out_onehot_c_idle", out_onehot_c, 0);
    end
    chk("word_cnt", word_cnt, mcnt);
    chk("word_cnt_c", word_cnt_c, mcnt_c);
`ifdef DEC_PARITY_EN
    chk("par_err", par_err, mpar);
    chk("par_err_c", par_err_c, mpar);
`endif
    if (!rst_n) begin
      sb_q.delete();
      mcnt = 0;
      mcnt_c = 0;
      mpar = 1'b0;
    end else begin
      hs = (sz > 0) && out_ready;
      if (hs) void'(sb_q.pop_front());
      if (in_valid && (sz < 2)) begin
        if (!PAR_EN || ((^{in_code, in_par}) == 1'b0)) sb_q.push_back(in_code);
        else mpar = 1'b1;
      end
      if (cnt_clr) begin
        mcnt = 0;
        mcnt_c = 0;
      end else if (hs) begin
        if (mcnt < 255) mcnt++;
        if (mcnt_c < 3) mcnt_c++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic p);
    bit done = 0;
    in_valid = 1'b1;
    in_code  = c;
    in_par   = p;
    for (int t = 0; t < 50 && !done; t++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb_q.size() != 0; t++) tick();
    chk("drain", sb_q.size(), 0);
  endtask

  int w0;

  initial begin
    // Reset held three cycles with in_valid asserted
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_code = 2'd3;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_onehot", out_onehot, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_out_code", out_code, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Full sweep with free-running output
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(2'(i), ^(2'(i)));
    drain();
    chk("sweep_word_cnt", word_cnt, 4);
    chk("sweep_word_cnt_c", word_cnt_c, 3);

    // Backpressure fills output and skid
    out_ready = 1'b0;
    send(2'd2, 1'b1);
    send(2'd3, 1'b0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_onehot", out_onehot, 4'b0100);
    repeat (3) tick();
    chk("bp_hold", out_onehot, 4'b0100);
    out_ready = 1'b1;
    tick();
    chk("bp_skid_out", out_onehot, 4'b1000);
    chk("bp_in_ready_back", in_ready, 1);
    drain();

    // Saturating counter on the CNT_W=2 instance
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(2'(i), ^(2'(i)));
      if (i > 0) chk("sat_seq", word_cnt_c, (i < 3) ? i : 3);
    end
    drain();
    chk("sat_final_c", word_cnt_c, 3);
    chk("sat_final", word_cnt, 5);

    // Clear coincident with output handshakes
    cnt_clr = 1'b1;
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    tick();
    cnt_clr = 1'b0;
    chk("clr_prio", word_cnt, 0);
    chk("clr_prio_c", word_cnt_c, 0);
    chk("clr_delivered", sb_q.size(), 0);

    // Reset while both stages are full
    out_ready = 1'b0;
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    chk("two_state", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("midrst_nothing", out_valid, 0);
    chk("midrst_cnt", word_cnt, 0);

`ifdef DEC_PARITY_EN
    // Bad parity dropped and flagged, good word still delivered
    w0 = int'(word_cnt);
    send(2'd1, 1'b0);
    repeat (2) tick();
    chk("par_err_set", par_err, 1);
    chk("par_drop_cnt", word_cnt, w0);
    chk("par_drop_valid", out_valid, 0);
    send(2'd1, 1'b1);
    chk("par_good_onehot", out_onehot, 4'b0010);
    drain();
    chk("par_err_sticky", par_err, 1);
    chk("par_good_cnt", word_cnt, w0 + 1);
`else
    w0 = 0;
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
